mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one memory port between the IFU (read-only) and LSU (read/write) of the multicycle core.
//  - Round-robin arbitration; one outstanding transaction at a time.
//  - Request payload is registered.
//  - Each response is routed back to the requester that owns the transaction.
//  - Watchdog timer: a hung transaction completes to its owner with an error response.
// PARAMETERS
//  ADDR_W   32   address width
//  DATA_W   32   data width; wmask width is DATA_W/8
//  TIMEOUT  255  cycles allowed in REQ+WAIT before the error response; 0 disables the watchdog
// PORTS
//  clk             in   1        clock
//  rst             in   1        synchronous reset, active-high
//  ifu_req_valid   in   1        IFU read request
//  ifu_req_ready   out  1        IFU request accepted
//  ifu_req_addr    in   ADDR_W   IFU address
//  ifu_resp_valid  out  1        IFU response valid
//  ifu_resp_ready  in   1        IFU can take the response
//  ifu_resp_data   out  DATA_W   IFU read data
//  ifu_resp_err    out  1        IFU bus error / timeout
//  lsu_req_valid   in   1        LSU request
//  lsu_req_ready   out  1        LSU request accepted
//  lsu_req_addr    in   ADDR_W   LSU address
//  lsu_req_wen     in   1        1 = write, 0 = read
//  lsu_req_wdata   in   DATA_W   write data
//  lsu_req_wmask   in   DATA_W/8 byte strobes
//  lsu_resp_valid  out  1        LSU response valid
//  lsu_resp_ready  in   1        LSU can take the response
//  lsu_resp_data   out  DATA_W   LSU read data (0 for writes)
//  lsu_resp_err    out  1        LSU bus error / timeout
//  mem_req_valid   out  1        request to memory
//  mem_req_ready   in   1        memory accepts the request
//  mem_req_addr    out  ADDR_W   registered address
//  mem_req_wen     out  1        registered write enable (IFU owner -> 0)
//  mem_req_wdata   out  DATA_W   registered write data
//  mem_req_wmask   out  DATA_W/8 registered strobes (IFU owner -> 0)
//  mem_resp_valid  in   1        memory response valid
//  mem_resp_ready  out  1        arbiter accepts the memory response
//  mem_resp_data   in   DATA_W   memory read data
//  mem_resp_err    in   1        memory error
//  owner           out  1        0 = IFU, 1 = LSU; meaningful only outside IDLE
// BEHAVIOUR
//  Reset (rst=1 at a clock edge):
//   - state=IDLE, last_owner=1 (LSU), so the first contention goes to the IFU.
//   - wdog=0; payload registers=0.
//   - While rst is high, every output is forced to 0.
//   - Reset mid-transaction abandons the transaction; no response is issued.
//  States: IDLE -> REQ -> WAIT -> IDLE, plus TOUT for the watchdog path.
//  IDLE:
//   - Grant: if only one requester is valid, grant it. If both are valid, grant the one that is not last_owner.
//   - The grant is combinational: the winner's *_req_ready=1 in that same cycle; the loser's ready=0.
//   - On the grant: latch the payload, set owner and last_owner, go to REQ.
//   - mem_resp_ready=1 in IDLE, so stray or late memory responses are consumed and dropped.
//  REQ:
//   - mem_req_valid=1 with the registered payload; both *_req_ready=0.
//   - On mem_req_ready=1, go to WAIT. The earliest mem_req_valid is the cycle after the grant.
//  WAIT:
//   - mem_req_valid=0.
//   - Owner's resp_valid = mem_resp_valid; owner's data/err come from mem_resp_*; mem_resp_ready = owner's resp_ready.
//   - Non-owner's resp_valid=0.
//   - When mem_resp_valid and the owner's resp_ready are both 1, go to IDLE. A new grant is possible the next cycle.
//  Watchdog:
//   - wdog counts +1 per cycle in REQ and WAIT; it clears on entry to REQ.
//   - In WAIT, a response handshake has priority over the watchdog.
//   - Otherwise, when wdog reaches TIMEOUT-1 and TIMEOUT!=0, go to TOUT.
//  TOUT:
//   - Owner's resp_valid=1, err=1, data=0; mem_req_valid=0; mem_resp_ready=1 (drops late responses).
//   - On the owner's resp_ready, go to IDLE.
//  Holding: payload registers and owner are stable from the grant to the return to IDLE.
//  Holding: a response is held stable while the owner's resp_valid=1 and resp_ready=0.
//  Width: wdog is $clog2(TIMEOUT+1) bits (min 1) and saturates; it never wraps.
// TESTING
//  1. Only ifu valid, addr=0x8000_0000. mem ready at once; resp data=0x0000_0013 after 2 cycles.
//     -> ifu_req_ready in cycle 0; mem_req_valid in cycle 1; ifu_resp_data=0x13, err=0.
//  2. Both valid every cycle, 4 transactions. -> grant order IFU, LSU, IFU, LSU; the loser's req_ready stays 0.
//  3. LSU write: addr=0x8000_1000, wdata=0xDEAD_BEEF, wmask=0xF.
//     -> mem_req_* carries exactly these values with wen=1; IFU outputs unchanged.
//  4. TIMEOUT=8, memory never responds. -> owner's resp_valid=1, err=1, data=0 at cycle 9 after the grant.
//     A late mem_resp in IDLE is dropped.
//  5. Response backpressure: lsu_resp_ready=0 for 3 cycles. -> mem_resp_ready=0 and data held stable; completes on ready.
//  6. rst asserted in WAIT. -> next cycle all outputs 0; state IDLE; the next contention is granted to the IFU.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - IFU, LSU and memory bus bundle for mem_bus_arbiter
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  ifu_req_valid;
    logic                  ifu_req_ready;
    logic [ADDR_W-1:0]     ifu_req_addr;
    logic                  ifu_resp_valid;
    logic                  ifu_resp_ready;
    logic [DATA_W-1:0]     ifu_resp_data;
    logic                  ifu_resp_err;

    logic                  lsu_req_valid;
    logic                  lsu_req_ready;
    logic [ADDR_W-1:0]     lsu_req_addr;
    logic                  lsu_req_wen;
    logic [DATA_W-1:0]     lsu_req_wdata;
    logic [DATA_W/8-1:0]   lsu_req_wmask;
    logic                  lsu_resp_valid;
    logic                  lsu_resp_ready;
    logic [DATA_W-1:0]     lsu_resp_data;
    logic                  lsu_resp_err;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_W-1:0]     mem_req_addr;
    logic                  mem_req_wen;
    logic [DATA_W-1:0]     mem_req_wdata;
    logic [DATA_W/8-1:0]   mem_req_wmask;
    logic                  mem_resp_valid;
    logic                  mem_resp_ready;
    logic [DATA_W-1:0]     mem_resp_data;
    logic                  mem_resp_err;

    logic                  owner;

    // Arbiter side
    modport master (
        input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
        input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask, lsu_resp_ready,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, mem_resp_ready,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
        output owner
    );

    // Requester and memory side
    modport slave (
        output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
        output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask, lsu_resp_ready,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, mem_resp_ready,
        output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
        input  owner
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin IFU/LSU arbiter for one memory port, with watchdog
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.master bus
);
    localparam int MASK_W = DATA_W / 8;
    localparam int WD_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_TOUT = 2'd3;

    logic [1:0]        state;
    logic              owner_q;
    logic [WD_W-1:0]   wdog;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;

    logic grant_ifu;
    logic grant_lsu;
    logic owner_rready;
    logic resp_hs;
    logic wdog_expired;

    // owner_q doubles as last_owner: it keeps the previous winner while idle
    always_comb begin
        grant_ifu    = (state == ST_IDLE) && bus.ifu_req_valid && (!bus.lsu_req_valid || owner_q);
        grant_lsu    = (state == ST_IDLE) && bus.lsu_req_valid && (!bus.ifu_req_valid || !owner_q);
        owner_rready = owner_q ? bus.lsu_resp_ready : bus.ifu_resp_ready;
        resp_hs      = (state == ST_WAIT) && bus.mem_resp_valid && owner_rready;
        wdog_expired = (TIMEOUT != 0) && (wdog == WD_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            owner_q <= 1'b1;
            wdog    <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_ifu || grant_lsu) begin
                        state   <= ST_REQ;
                        owner_q <= grant_lsu;
                        wdog    <= '0;
                        addr_q  <= grant_lsu ? bus.lsu_req_addr : bus.ifu_req_addr;
                        wen_q   <= grant_lsu && bus.lsu_req_wen;
                        wdata_q <= grant_lsu ? bus.lsu_req_wdata : '0;
                        wmask_q <= grant_lsu ? bus.lsu_req_wmask : '0;
                    end
                end
                ST_REQ: begin
                    if (wdog_expired) begin
                        state <= ST_TOUT;
                    end else if (bus.mem_req_ready) begin
                        state <= ST_WAIT;
                    end
                    if (wdog != '1) begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (resp_hs) begin
                        state <= ST_IDLE;
                    end else if (wdog_expired) begin
                        state <= ST_TOUT;
                    end
                    if (wdog != '1) begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ST_TOUT: begin
                    if (owner_rready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Every output is held at zero while rst is high, independent of state
    always_comb begin
        bus.ifu_req_ready  = 1'b0;
        bus.lsu_req_ready  = 1'b0;
        bus.ifu_resp_valid = 1'b0;
        bus.ifu_resp_data  = '0;
        bus.ifu_resp_err   = 1'b0;
        bus.lsu_resp_valid = 1'b0;
        bus.lsu_resp_data  = '0;
        bus.lsu_resp_err   = 1'b0;
        bus.mem_req_valid  = 1'b0;
        bus.mem_req_addr   = '0;
        bus.mem_req_wen    = 1'b0;
        bus.mem_req_wdata  = '0;
        bus.mem_req_wmask  = '0;
        bus.mem_resp_ready = 1'b0;
        bus.owner          = 1'b0;
        if (!rst) begin
            bus.ifu_req_ready = grant_ifu;
            bus.lsu_req_ready = grant_lsu;
            bus.mem_req_valid = (state == ST_REQ);
            bus.mem_req_addr  = addr_q;
            bus.mem_req_wen   = wen_q;
            bus.mem_req_wdata = wdata_q;
            bus.mem_req_wmask = wmask_q;
            bus.owner         = owner_q;
            case (state)
                ST_IDLE: bus.mem_resp_ready = 1'b1;
                ST_WAIT: begin
                    bus.mem_resp_ready = owner_rready;
                    if (owner_q) begin
                        bus.lsu_resp_valid = bus.mem_resp_valid;
                        bus.lsu_resp_data  = wen_q ? '0 : bus.mem_resp_data;
                        bus.lsu_resp_err   = bus.mem_resp_err;
                    end else begin
                        bus.ifu_resp_valid = bus.mem_resp_valid;
                        bus.ifu_resp_data  = bus.mem_resp_data;
                        bus.ifu_resp_err   = bus.mem_resp_err;
                    end
                end
                ST_TOUT: begin
                    bus.mem_resp_ready = 1'b1;
                    if (owner_q) begin
                        bus.lsu_resp_valid = 1'b1;
                        bus.lsu_resp_err   = 1'b1;
                    end else begin
                        bus.ifu_resp_valid = 1'b1;
                        bus.ifu_resp_err   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - table, directed and randomized checks for mem_bus_arbiter
module tb_mem_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        iv;
        logic        lv;
        logic        lwen;
        logic [31:0] addr_i;
        logic [31:0] addr_l;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] rdata;
        logic        rerr;
        logic        exp_owner;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        bus.ifu_req_valid  = 0; bus.ifu_req_addr = '0; bus.ifu_resp_ready = 0;
        bus.lsu_req_valid  = 0; bus.lsu_req_addr = '0; bus.lsu_req_wen = 0;
        bus.lsu_req_wdata  = '0; bus.lsu_req_wmask = '0; bus.lsu_resp_ready = 0;
        bus.mem_req_ready  = 0; bus.mem_resp_valid = 0; bus.mem_resp_data = '0; bus.mem_resp_err = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ifu_req_ready"}, bus.ifu_req_ready, 0);
        check({tag, "_lsu_req_ready"}, bus.lsu_req_ready, 0);
        check({tag, "_ifu_resp_valid"}, bus.ifu_resp_valid, 0);
        check({tag, "_lsu_resp_valid"}, bus.lsu_resp_valid, 0);
        check({tag, "_mem_req_valid"}, bus.mem_req_valid, 0);
        check({tag, "_mem_resp_ready"}, bus.mem_resp_ready, 0);
        check({tag, "_owner"}, bus.owner, 0);
        check({tag, "_mem_req_addr"}, bus.mem_req_addr, 0);
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        logic own;
        own = v.exp_owner;
        bus.ifu_req_valid = v.iv; bus.ifu_req_addr = v.addr_i;
        bus.lsu_req_valid = v.lv; bus.lsu_req_addr = v.addr_l; bus.lsu_req_wen = v.lwen;
        bus.lsu_req_wdata = v.wdata; bus.lsu_req_wmask = v.wmask;
        settle();
        check({tag, "_ifu_req_ready"}, bus.ifu_req_ready, !own);
        check({tag, "_lsu_req_ready"}, bus.lsu_req_ready, own);
        check({tag, "_idle_mem_req_valid"}, bus.mem_req_valid, 0);
        cyc();
        // both requesters keep pushing new payloads; nothing may leak through
        bus.ifu_req_valid = 1; bus.ifu_req_addr = 32'h1111_1110;
        bus.lsu_req_valid = 1; bus.lsu_req_addr = 32'h2222_2220; bus.lsu_req_wen = !v.lwen;
        bus.lsu_req_wdata = 32'h5A5A_5A5A; bus.lsu_req_wmask = ~v.wmask;
        settle();
        check({tag, "_mem_req_valid"}, bus.mem_req_valid, 1);
        check({tag, "_mem_req_addr"}, bus.mem_req_addr, own ? v.addr_l : v.addr_i);
        check({tag, "_mem_req_wen"}, bus.mem_req_wen, own & v.lwen);
        check({tag, "_mem_req_wmask"}, bus.mem_req_wmask, own ? v.wmask : 4'h0);
        if (own) check({tag, "_mem_req_wdata"}, bus.mem_req_wdata, v.wdata);
        check({tag, "_owner"}, bus.owner, own);
        check({tag, "_busy_ifu_ready"}, bus.ifu_req_ready, 0);
        check({tag, "_busy_lsu_ready"}, bus.lsu_req_ready, 0);
        bus.mem_req_ready = 1;
        cyc();
        bus.mem_req_ready = 0;
        settle();
        check({tag, "_wait_mem_req_valid"}, bus.mem_req_valid, 0);
        check({tag, "_wait_no_resp"}, own ? bus.lsu_resp_valid : bus.ifu_resp_valid, 0);
        check({tag, "_wait_busy_ready"}, bus.ifu_req_ready | bus.lsu_req_ready, 0);
        cyc();
        bus.mem_resp_valid = 1; bus.mem_resp_data = v.rdata; bus.mem_resp_err = v.rerr;
        bus.ifu_resp_ready = 1; bus.lsu_resp_ready = 1;
        settle();
        check({tag, "_resp_valid"}, own ? bus.lsu_resp_valid : bus.ifu_resp_valid, 1);
        check({tag, "_other_resp_valid"}, own ? bus.ifu_resp_valid : bus.lsu_resp_valid, 0);
        check({tag, "_resp_data"}, own ? bus.lsu_resp_data : bus.ifu_resp_data,
              (own && v.lwen) ? 32'h0 : v.rdata);
        check({tag, "_resp_err"}, own ? bus.lsu_resp_err : bus.ifu_resp_err, v.rerr);
        check({tag, "_mem_resp_ready"}, bus.mem_resp_ready, 1);
        cyc();
        clear_inputs();
    endtask

    // randomized-phase model and agent state
    bit          m_busy, m_acc, m_last, m_own;
    logic [31:0] m_addr, m_wdata;
    logic        m_wen;
    logic [3:0]  m_wmask;
    bit          i_valid, i_wait, l_valid, l_wait;
    logic [31:0] i_addr, l_addr, l_wdata;
    logic        l_wen;
    logic [3:0]  l_wmask;
    int          i_st, l_st, mem_stall, mem_dly, done_txn;
    bit          mem_pend, mem_pres;
    logic [31:0] mem_data;
    logic        mem_err;

    initial begin
        bit exp_ig, exp_lg, exp_mrv, exp_iv, exp_lv, own_rdy;

        tbl[0] = '{1, 0, 0, 32'h8000_0000, 32'h0,         32'h0,         4'h0, 32'h0000_0013, 0, 0};
        tbl[1] = '{1, 1, 1, 32'h8000_0100, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 32'h1234_5678, 0, 1};
        tbl[2] = '{1, 1, 0, 32'h8000_0004, 32'h8000_2000, 32'h0,         4'hF, 32'h0000_0093, 0, 0};
        tbl[3] = '{1, 1, 0, 32'h8000_0008, 32'h8000_2004, 32'h0,         4'hF, 32'hAAAA_5555, 1, 1};
        tbl[4] = '{0, 1, 1, 32'h0,         32'h8000_3000, 32'h0102_0304, 4'h3, 32'h7777_7777, 0, 1};
        tbl[5] = '{1, 1, 0, 32'h8000_000C, 32'h8000_3004, 32'h0,         4'hF, 32'h0010_0073, 1, 0};
        tbl[6] = '{1, 0, 0, 32'h8000_0010, 32'h0,         32'h0,         4'h0, 32'h0000_0297, 0, 0};
        tbl[7] = '{1, 1, 0, 32'h8000_0014, 32'h8000_4000, 32'h0,         4'hF, 32'hC0DE_0001, 0, 1};

        clear_inputs();
        rst = 1;
        bus.ifu_req_valid = 1; bus.lsu_req_valid = 1; bus.mem_resp_valid = 1;
        settle();
        check_all_zero("rst_hold");
        cyc();
        cyc();
        clear_inputs();
        rst = 0;
        settle();
        check("reset_mem_req_valid", bus.mem_req_valid, 0);
        check("reset_mem_resp_ready", bus.mem_resp_ready, 1);
        check("reset_mem_req_addr", bus.mem_req_addr, 0);
        check("reset_req_ready", bus.ifu_req_ready | bus.lsu_req_ready, 0);

        for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

        // watchdog: IFU read accepted by memory, never answered
        bus.ifu_req_valid = 1; bus.ifu_req_addr = 32'h8000_0040;
        settle();
        check("tout_grant", bus.ifu_req_ready, 1);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            clear_inputs();
            bus.mem_req_ready = (k == 1);
            settle();
            check($sformatf("tout_c%0d_mem_req_valid", k), bus.mem_req_valid, k == 1);
            check($sformatf("tout_c%0d_ifu_resp_valid", k), bus.ifu_resp_valid, k >= 9);
            if (k >= 9) begin
                check($sformatf("tout_c%0d_err", k), bus.ifu_resp_err, 1);
                check($sformatf("tout_c%0d_data", k), bus.ifu_resp_data, 0);
                check($sformatf("tout_c%0d_mem_resp_ready", k), bus.mem_resp_ready, 1);
                check($sformatf("tout_c%0d_lsu_resp_valid", k), bus.lsu_resp_valid, 0);
            end
        end
        bus.ifu_resp_ready = 1;
        cyc();
        clear_inputs();
        bus.mem_resp_valid = 1; bus.mem_resp_data = 32'h0000_0BAD; bus.mem_resp_err = 1;
        settle();
        check("late_resp_ready", bus.mem_resp_ready, 1);
        check("late_ifu_resp_valid", bus.ifu_resp_valid, 0);
        check("late_lsu_resp_valid", bus.lsu_resp_valid, 0);
        cyc();
        clear_inputs();
        settle();
        check("late_still_idle", bus.mem_req_valid, 0);

        // response backpressure on an LSU read
        bus.lsu_req_valid = 1; bus.lsu_req_addr = 32'h8000_2000;
        settle();
        check("bp_grant", bus.lsu_req_ready, 1);
        cyc();
        clear_inputs();
        bus.mem_req_ready = 1;
        cyc();
        clear_inputs();
        for (int k = 0; k < 4; k++) begin
            bus.mem_resp_valid = 1; bus.mem_resp_data = 32'hCAFE_F00D;
            bus.lsu_resp_ready = (k == 3);
            settle();
            check($sformatf("bp%0d_valid", k), bus.lsu_resp_valid, 1);
            check($sformatf("bp%0d_data", k), bus.lsu_resp_data, 32'hCAFE_F00D);
            check($sformatf("bp%0d_mem_resp_ready", k), bus.mem_resp_ready, k == 3);
            cyc();
        end
        clear_inputs();
        settle();
        check("bp_done_valid", bus.lsu_resp_valid, 0);
        check("bp_done_idle", bus.mem_resp_ready, 1);

        // reset while an IFU transaction waits; IFU must still win the next contention
        bus.ifu_req_valid = 1; bus.ifu_req_addr = 32'h8000_0080;
        settle();
        check("rw_grant", bus.ifu_req_ready, 1);
        cyc();
        clear_inputs();
        bus.mem_req_ready = 1;
        cyc();
        clear_inputs();
        rst = 1;
        bus.mem_resp_valid = 1; bus.mem_resp_data = 32'h1234_0000; bus.ifu_resp_ready = 1;
        bus.ifu_req_valid = 1; bus.lsu_req_valid = 1;
        settle();
        check_all_zero("rw_rst");
        cyc();
        settle();
        check_all_zero("rw_rst2");
        rst = 0;
        clear_inputs();
        bus.ifu_req_valid = 1; bus.lsu_req_valid = 1;
        settle();
        check("rw_after_ifu_ready", bus.ifu_req_ready, 1);
        check("rw_after_lsu_ready", bus.lsu_req_ready, 0);
        check("rw_after_no_resp", bus.ifu_resp_valid, 0);

        // clean restart for the randomized phase
        cyc();
        clear_inputs();
        rst = 1;
        cyc();
        rst = 0;
        m_busy = 0; m_acc = 0; m_last = 1; m_own = 0;
        i_valid = 0; i_wait = 0; l_valid = 0; l_wait = 0;
        i_st = 0; l_st = 0; mem_stall = 0; mem_dly = 0; mem_pend = 0; done_txn = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c != 0) cyc();
            if (!i_valid && !i_wait && ($urandom % 2 == 1)) begin
                i_valid = 1; i_addr = $urandom;
            end
            if (!l_valid && !l_wait && ($urandom % 2 == 1)) begin
                l_valid = 1; l_addr = $urandom; l_wen = $urandom % 2;
                l_wdata = $urandom; l_wmask = 4'($urandom);
            end
            bus.ifu_req_valid = i_valid; bus.ifu_req_addr = i_addr;
            bus.lsu_req_valid = l_valid; bus.lsu_req_addr = l_addr; bus.lsu_req_wen = l_wen;
            bus.lsu_req_wdata = l_wdata; bus.lsu_req_wmask = l_wmask;
            bus.mem_req_ready = (mem_stall >= 2) || ($urandom % 2 == 1);
            mem_pres = mem_pend && (mem_dly == 0);
            bus.mem_resp_valid = mem_pres; bus.mem_resp_data = mem_data; bus.mem_resp_err = mem_err;
            bus.ifu_resp_ready = (i_st >= 2) || ($urandom % 2 == 1);
            bus.lsu_resp_ready = (l_st >= 2) || ($urandom % 2 == 1);
            settle();

            exp_ig  = !m_busy && i_valid && (!l_valid || m_last);
            exp_lg  = !m_busy && l_valid && (!i_valid || !m_last);
            exp_mrv = m_busy && !m_acc;
            exp_iv  = m_busy && m_acc && !m_own && mem_pres;
            exp_lv  = m_busy && m_acc && m_own && mem_pres;
            own_rdy = m_own ? bus.lsu_resp_ready : bus.ifu_resp_ready;
            check("rnd_ifu_req_ready", bus.ifu_req_ready, exp_ig);
            check("rnd_lsu_req_ready", bus.lsu_req_ready, exp_lg);
            check("rnd_mem_req_valid", bus.mem_req_valid, exp_mrv);
            check("rnd_ifu_resp_valid", bus.ifu_resp_valid, exp_iv);
            check("rnd_lsu_resp_valid", bus.lsu_resp_valid, exp_lv);
            if (m_busy) check("rnd_owner", bus.owner, m_own);
            if (exp_mrv && bus.mem_req_ready) begin
                check("rnd_req_addr", bus.mem_req_addr, m_addr);
                check("rnd_req_wen", bus.mem_req_wen, m_wen);
                check("rnd_req_wmask", bus.mem_req_wmask, m_wmask);
                if (m_own) check("rnd_req_wdata", bus.mem_req_wdata, m_wdata);
            end
            if (exp_iv) begin
                check("rnd_ifu_data", bus.ifu_resp_data, mem_data);
                check("rnd_ifu_err", bus.ifu_resp_err, mem_err);
            end
            if (exp_lv) begin
                check("rnd_lsu_data", bus.lsu_resp_data, m_wen ? 32'h0 : mem_data);
                check("rnd_lsu_err", bus.lsu_resp_err, mem_err);
            end
            if (!m_busy || m_acc) check("rnd_mem_resp_ready", bus.mem_resp_ready, m_busy ? own_rdy : 1'b1);

            // state changes that take effect at the coming clock edge
            if (m_busy && m_acc && mem_pres && own_rdy) begin
                m_busy = 0; done_txn++;
                if (m_own) l_wait = 0; else i_wait = 0;
            end
            if (exp_mrv && bus.mem_req_ready) m_acc = 1;
            if (exp_ig || exp_lg) begin
                m_busy = 1; m_acc = 0; m_own = exp_lg; m_last = exp_lg;
                m_addr  = exp_lg ? l_addr : i_addr;
                m_wen   = exp_lg && l_wen;
                m_wdata = l_wdata;
                m_wmask = exp_lg ? l_wmask : 4'h0;
                if (exp_lg) begin l_valid = 0; l_wait = 1; end
                else begin i_valid = 0; i_wait = 1; end
            end
            if (mem_pres && bus.mem_resp_ready) mem_pend = 0;
            else if (mem_pend && mem_dly > 0) mem_dly--;
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                mem_pend = 1; mem_dly = $urandom % 2; mem_data = $urandom;
                mem_err = ($urandom % 8 == 0); mem_stall = 0;
            end else if (bus.mem_req_valid) begin
                mem_stall++;
            end
            if (bus.ifu_resp_valid && !bus.ifu_resp_ready) i_st++; else i_st = 0;
            if (bus.lsu_resp_valid && !bus.lsu_resp_ready) l_st++; else l_st = 0;
        end
        check("rnd_progress", done_txn > 200, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
